// File: rtl/quad_lo_synth_if.sv
// Control and switch-drive bundle for the quadrature LO generator.
// Latency: none (wires only).
// Backpressure: none; tuning requests are single-cycle strobes.
//
// Signals:
//   enable        run the phase accumulator; outputs off when low
//   freq_word     tuning word, f_out = f_clk * freq_word / 2^ACC_W
//   freq_strobe   one-cycle request to load freq_word
//   update_mode   1 = apply immediately, 0 = apply at next accumulator wrap
//   phase_offset  rotation added to the phase index
//   phase_out     one-hot (or all-zero) analog switch drive
//   phase_idx     index being driven, or last driven while off
//   wrap          one-cycle pulse on accumulator carry-out
//   busy          a wrap-mode update is pending
//   locked        running at the commanded frequency
//   err           one-cycle pulse when a strobe is rejected
interface quad_lo_synth_if #(
  parameter int ACC_W      = 32,
  parameter int PHASE_BITS = 2
);
  localparam int NPH = 1 << PHASE_BITS;

  logic                  enable;
  logic [ACC_W-1:0]      freq_word;
  logic                  freq_strobe;
  logic                  update_mode;
  logic [PHASE_BITS-1:0] phase_offset;
  logic [NPH-1:0]        phase_out;
  logic [PHASE_BITS-1:0] phase_idx;
  logic                  wrap;
  logic                  busy;
  logic                  locked;
  logic                  err;

  modport master (
    output enable, freq_word, freq_strobe, update_mode, phase_offset,
    input  phase_out, phase_idx, wrap, busy, locked, err
  );

  modport slave (
    input  enable, freq_word, freq_strobe, update_mode, phase_offset,
    output phase_out, phase_idx, wrap, busy, locked, err
  );
endinterface

// File: rtl/quad_lo_synth.sv
// Quadrature LO: phase-accumulator NCO decoded to a one-hot switch drive with dead time.
// Latency: strobe effects 1 cycle; phase_out follows acc by 1 cycle (+DEAD_CYCLES at transitions).
// Backpressure: none; one accumulator add every cycle.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    quad_lo_synth_if.slave (tuning inputs, switch drive and status outputs)
module quad_lo_synth #(
  parameter int ACC_W       = 32,
  parameter int PHASE_BITS  = 2,
  parameter int DEAD_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  quad_lo_synth_if.slave  bus
);
  localparam int NPH = 1 << PHASE_BITS;
  // Dead counter counts down to zero, so it is loaded with one less than the gap length.
  localparam logic [1:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? 2'(DEAD_CYCLES - 1) : 2'd0;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON   = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  function automatic logic [NPH-1:0] f_onehot(input logic [PHASE_BITS-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  // ---------------------------------------------------------------- NCO
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      r_active_word;
  logic [ACC_W-1:0]      r_pending_word;
  logic                  r_busy;
  logic                  r_locked;
  logic                  r_wrap;
  logic                  r_err;

  logic [ACC_W:0]        w_sum;
  logic                  w_carry;
  logic                  w_range_bad;
  logic                  w_strobe_ok;
  logic [PHASE_BITS-1:0] w_idx;

  assign w_sum       = {1'b0, r_acc} + {1'b0, r_active_word};
  assign w_carry     = w_sum[ACC_W];
  // Any of the top PHASE_BITS set means the word could skip a phase per cycle.
  assign w_range_bad = |bus.freq_word[ACC_W-1 -: PHASE_BITS];
  assign w_strobe_ok = bus.freq_strobe & ~w_range_bad;
  assign w_idx       = r_acc[ACC_W-1 -: PHASE_BITS] + bus.phase_offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc          <= '0;
      r_active_word  <= '0;
      r_pending_word <= '0;
      r_busy         <= 1'b0;
      r_locked       <= 1'b0;
      r_wrap         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_err    <= bus.freq_strobe & w_range_bad;
      r_wrap   <= bus.enable & w_carry;
      r_locked <= bus.enable & ~r_busy & (r_active_word != '0);
      if (bus.enable) begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      // The carry cycle still adds the old word; the new one takes effect after it.
      // With the accumulator stopped there is no wrap to wait for, so apply at once.
      if (r_busy && (!bus.enable || w_carry)) begin
        r_active_word <= r_pending_word;
        r_busy        <= 1'b0;
      end
      // A fresh strobe overrides whatever the pending logic did this cycle.
      if (w_strobe_ok) begin
        if (bus.update_mode) begin
          r_active_word <= bus.freq_word;
          r_busy        <= 1'b0;
        end else begin
          r_pending_word <= bus.freq_word;
          r_busy         <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------- output FSM
  state_t                r_state;
  logic [PHASE_BITS-1:0] r_phase_idx;
  logic [NPH-1:0]        r_phase_out;
  logic [1:0]            r_dead_cnt;

  state_t                w_state_nxt;
  logic [PHASE_BITS-1:0] w_phase_idx_nxt;
  logic [NPH-1:0]        w_phase_out_nxt;
  logic [1:0]            w_dead_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_OFF;
      r_phase_idx <= '0;
      r_phase_out <= '0;
      r_dead_cnt  <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_idx <= w_phase_idx_nxt;
      r_phase_out <= w_phase_out_nxt;
      r_dead_cnt  <= w_dead_cnt_nxt;
    end
  end

  // Every path either drives onehot(one index) or all-zero, so at most one switch is closed.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_idx_nxt = r_phase_idx;
    w_phase_out_nxt = r_phase_out;
    w_dead_cnt_nxt  = r_dead_cnt;
    if (!bus.enable) begin
      w_state_nxt     = S_OFF;
      w_phase_out_nxt = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt     = S_ON;
          w_phase_idx_nxt = w_idx;
          w_phase_out_nxt = f_onehot(w_idx);
        end
        S_ON: begin
          w_phase_out_nxt = f_onehot(r_phase_idx);
          if (w_idx != r_phase_idx) begin
            if (DEAD_CYCLES == 0) begin
              w_phase_idx_nxt = w_idx;
              w_phase_out_nxt = f_onehot(w_idx);
            end else begin
              w_state_nxt     = S_DEAD;
              w_phase_out_nxt = '0;
              w_dead_cnt_nxt  = DEAD_LOAD;
            end
          end
        end
        S_DEAD: begin
          w_phase_out_nxt = '0;
          // Index changes inside the gap do not restart it; the latest idx is taken at exit.
          if (r_dead_cnt == 2'd0) begin
            w_state_nxt     = S_ON;
            w_phase_idx_nxt = w_idx;
            w_phase_out_nxt = f_onehot(w_idx);
          end else begin
            w_dead_cnt_nxt = r_dead_cnt - 2'd1;
          end
        end
        default: begin
          w_state_nxt     = S_OFF;
          w_phase_out_nxt = '0;
        end
      endcase
    end
  end

  assign bus.phase_out = r_phase_out;
  assign bus.phase_idx = r_phase_idx;
  assign bus.wrap      = r_wrap;
  assign bus.busy      = r_busy;
  assign bus.locked    = r_locked;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_quad_lo_synth.sv
// Bench for quad_lo_synth: two instances (no dead time / one dead cycle) share stimulus.
// Expected outputs per cycle are queued by the stimulus and checked by a separate monitor.
module tb_quad_lo_synth;
  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] freq_word;
  logic       freq_strobe;
  logic       update_mode;
  logic [1:0] phase_offset;

  quad_lo_synth_if #(.ACC_W(8), .PHASE_BITS(2)) if0 ();
  quad_lo_synth_if #(.ACC_W(8), .PHASE_BITS(2)) if1 ();

  assign if0.enable       = enable;
  assign if0.freq_word    = freq_word;
  assign if0.freq_strobe  = freq_strobe;
  assign if0.update_mode  = update_mode;
  assign if0.phase_offset = phase_offset;
  assign if1.enable       = enable;
  assign if1.freq_word    = freq_word;
  assign if1.freq_strobe  = freq_strobe;
  assign if1.update_mode  = update_mode;
  assign if1.phase_offset = phase_offset;

  quad_lo_synth #(.ACC_W(8), .PHASE_BITS(2), .DEAD_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  quad_lo_synth #(.ACC_W(8), .PHASE_BITS(2), .DEAD_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] po0;
    logic [3:0] po1;
    logic       wrap;
    logic       busy;
    logic       locked;
    logic       err;
    logic       chk_idx;
    logic [1:0] idx0;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   scyc  = 0;
  int   mcyc  = 0;

  function automatic logic [3:0] oh(input int p);
    logic [3:0] r;
    logic [1:0] b;
    b    = p[1:0];
    r    = 4'b0000;
    r[b] = 1'b1;
    return r;
  endfunction

  // Hand-derived outputs after edge n (word 16: acc = 16*(n-3); word 32 from edge 35 on).
  function automatic exp_t build(input int n);
    exp_t e;
    int k, m, p, off;
    e.cyc = n; e.po0 = 4'b0; e.po1 = 4'b0; e.wrap = 1'b0; e.busy = 1'b0;
    e.locked = 1'b0; e.err = 1'b0; e.chk_idx = 1'b0; e.idx0 = 2'd0;
    if (n <= 2) begin
      e.chk_idx = 1'b1;
    end else if (n == 3) begin
      e.po0 = 4'b0001; e.po1 = 4'b0001;
    end else if (n <= 35) begin
      k      = n - 4;
      e.po0  = oh((k % 16) / 4);
      e.po1  = (n >= 8 && k % 4 == 0) ? 4'b0000 : e.po0;
      e.wrap = ((n - 3) % 16 == 0);
      e.busy = (n >= 25 && n <= 34);
      e.locked = !(n >= 26 && n <= 35);
      e.err  = (n == 22);
    end else if ((n >= 36 && n <= 49) || (n >= 54 && n <= 60)) begin
      m     = (n >= 54) ? n - 4 : n;
      off   = (n >= 45) ? 1 : 0;
      p     = (((m - 36) % 8) / 2 + off) % 4;
      e.po0 = oh(p);
      e.po1 = ((m - 36) % 2 == 0 && n != 54) ? 4'b0000 : e.po0;
      e.wrap   = ((m - 35) % 8 == 0);
      e.locked = 1'b1;
      e.busy   = (n == 60);
    end else if (n >= 50 && n <= 53) begin
      e.chk_idx = 1'b1; e.idx0 = 2'd3;
    end else if (n == 61 || n == 62) begin
      e.chk_idx = 1'b1;
    end else begin
      e.po0 = 4'b0001; e.po1 = 4'b0001; e.chk_idx = 1'b1;
    end
    return e;
  endfunction

  // Inputs to be sampled at edge n.
  task automatic apply(input int n);
    reset        = (n <= 2) || (n == 61) || (n == 62);
    enable       = (n >= 3) && !(n >= 50 && n <= 53);
    phase_offset = (n >= 45 && n <= 60) ? 2'd1 : 2'd0;
    freq_strobe  = 1'b0;
    update_mode  = 1'b0;
    freq_word    = 8'd0;
    case (n)
      3:  begin freq_strobe = 1'b1; freq_word = 8'd16; update_mode = 1'b1; end
      22: begin freq_strobe = 1'b1; freq_word = 8'd64; update_mode = 1'b1; end
      25: begin freq_strobe = 1'b1; freq_word = 8'd32; update_mode = 1'b0; end
      60: begin freq_strobe = 1'b1; freq_word = 8'd16; update_mode = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    scyc++;
    #1;
  endtask

  task automatic chk(input string nm, input int cyc, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  // Monitor: every cycle, compare the DUT outputs against the queued expectation for that cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      mcyc++;
      #2;
      while (q.size() > 0 && q[0].cyc <= mcyc) begin
        e = q.pop_front();
        if (e.cyc < mcyc) begin
          tests++;
          fails++;
          $display("FAIL stale_entry cyc=%0d got=unchecked exp=checked_at_%0d", mcyc, e.cyc);
        end else begin
          chk("phase_out0", mcyc, if0.phase_out, e.po0);
          chk("phase_out1", mcyc, if1.phase_out, e.po1);
          chk("wrap",       mcyc, {3'b0, if0.wrap},   {3'b0, e.wrap});
          chk("busy",       mcyc, {3'b0, if0.busy},   {3'b0, e.busy});
          chk("locked",     mcyc, {3'b0, if0.locked}, {3'b0, e.locked});
          chk("err",        mcyc, {3'b0, if0.err},    {3'b0, e.err});
          chk("wrap1",      mcyc, {3'b0, if1.wrap},   {3'b0, e.wrap});
          chk("onehot1",    mcyc, {3'b0, ($countones(if1.phase_out) <= 1)}, 4'b0001);
          if (e.chk_idx) begin
            chk("phase_idx0", mcyc, {2'b0, if0.phase_idx}, {2'b0, e.idx0});
          end
        end
      end
    end
  end

  initial begin
    for (int n = 1; n <= 70; n++) begin
      apply(n);
      q.push_back(build(n));
      tick();
    end
    tick();
    tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quad_lo_synth.md
# quad_lo_synth

Parametrised quadrature local-oscillator generator for the receiver front end. A phase-accumulator NCO is clocked directly from the 50 MHz system clock, and its top bits are decoded into a one-hot phase set that drives the sampling analog switches. The block supersedes the fixed 2-bit counter plus PLL-reconfiguration approach. Tuning is phase-continuous, applied either immediately or at the accumulator wrap, and a configurable break-before-make dead time keeps two switches from ever being closed at once.

## Interface
- ACC_W, 32: accumulator and frequency-word width.
- PHASE_BITS, 2: output phase-index width; the number of outputs is NPH = 2^PHASE_BITS (4 gives quadrature).
- DEAD_CYCLES, 0: all-off clock cycles inserted at every phase transition (0..3).

- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run the accumulator. When 0, the accumulator holds and all outputs are off.
- freq_word  in  ACC_W  tuning word; f_out = f_clk·freq_word/2^ACC_W.
- freq_strobe  in  1  single-cycle request to load freq_word.
- update_mode  in  1  sampled with the strobe: 0 = apply at next accumulator wrap, 1 = apply immediately.
- phase_offset  in  PHASE_BITS  rotation added to the phase index, mod NPH.
- phase_out  out  NPH  one-hot switch drive, or all-zero.
- phase_idx  out  PHASE_BITS  index currently driven, or last driven while off.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- busy  out  1  a wrap-mode update is pending.
- locked  out  1  running at the commanded frequency.
- err  out  1  one-cycle pulse when a strobe is rejected.

## Operation
- **Reset values:** acc, active_word, pending_word, busy, locked, phase_out, phase_idx, wrap, err and the dead counter are all 0.
- **Accumulator:** when enable=1, acc <= acc + active_word (mod 2^ACC_W). The carry-out sets wrap=1 on the following cycle.
- **Phase index:** idx = acc[ACC_W-1 -: PHASE_BITS] + phase_offset, mod NPH.
- **Range check:** a strobe with freq_word ≥ 2^(ACC_W−PHASE_BITS) is rejected.
  - err pulses.
  - active_word, pending_word and busy are unchanged.
  - This guarantees every phase is visited in order.
- **Immediate mode (update_mode=1):** active_word <= freq_word. Any pending update is cancelled and busy clears.
- **Wrap mode (update_mode=0):** pending_word <= freq_word and busy=1.
  - The cycle that produces the carry still adds the old word; active_word <= pending_word in that same cycle.
  - busy clears at the same time.
  - A strobe while busy replaces pending_word (last wins).
- **Update while disabled:** if enable=0, a pending update is applied on the next cycle regardless of mode.
- **Locked:** locked = enable & ~busy & (active_word≠0), registered.
- **Output state machine:** states ON, DEAD, OFF.
  - ON: phase_out = onehot(phase_idx).
    - If idx≠phase_idx and DEAD_CYCLES=0: phase_idx <= idx and stay ON.
    - If idx≠phase_idx and DEAD_CYCLES>0: phase_out <= 0, load the dead counter with DEAD_CYCLES−1, go to DEAD.
  - DEAD: phase_out=0.
    - When the counter reaches 0: phase_idx <= current idx, go to ON.
    - An idx change during DEAD does not restart the count; the latest idx is taken at exit.
  - OFF: entered from any state when enable=0 (phase_out <= 0). Leaves to ON with the current idx when enable=1.
  - Two bits of phase_out are never high in the same cycle, in any state.
- **phase_offset:** a change is treated like any idx change, including dead time.
- **Reset mid-operation:** everything returns to reset values on the next edge. A pending update is discarded.

## Timing
- **Strobe latency:** strobe at edge N; busy, err and the immediate-mode active_word update are visible after edge N+1.
- **Output latency:** phase_out follows acc by 1 cycle (DEAD_CYCLES=0). A new index appears DEAD_CYCLES cycles later than that otherwise.
- **Enable:** enable low at edge N gives phase_out=0 after edge N+1.
- **Dead-time constraint:** DEAD_CYCLES must be smaller than the phase dwell 2^(ACC_W−PHASE_BITS)/freq_word. Violating it makes phases shorten or disappear, but outputs stay one-hot or zero.
- **Throughput:** one accumulator add per cycle; no backpressure.

## Test plan
- **Basic rotation** (ACC_W=8, PHASE_BITS=2, DEAD_CYCLES=0): reset, enable=1, strobe word 16 immediate → phase_out cycles 0001,0010,0100,1000, 4 cycles each; wrap every 16 cycles; locked=1.
- **Range check:** strobe word 64 → err single pulse; the frequency is unchanged and the rotation continues at word 16.
- **Wrap-mode update:** running word 16, strobe word 32 (mode 0) at acc=0x50 → busy=1 until the wrap at 0xF0→0x00; then 2-cycle phases; locked drops while busy.
- **Dead time** (DEAD_CYCLES=1, word 16): each phase is 3 cycles on, 1 cycle all-zero; no cycle has two bits set.
- **Offset and disable:** phase_offset=1 shifts the sequence by one phase; enable=0 → phase_out=0 next cycle and acc held; re-enable → resumes from the held phase.
- **Reset mid-operation:** reset during busy with DEAD active → all outputs 0, busy=0, pending discarded, acc=0.
